credit_rom_sequencer: RTL and testbench
=======================================

// Module: credit_rom_sequencer
// PURPOSE
//  Executes the micro-ROM selected by the key decoder's 3-bit rom_num and updates a
//  3-digit BCD credit balance (hundreds/tens/ones) one micro-op per clock.
//  Sits directly downstream of the key decoder; its digits feed the display/vend logic.
//  Codes: 0 add one, 1 add ten, 2 add hundred, 3 reset credit; 4..7 = no command.
// PARAMETERS
//  IDLE_CODE  4  rom_num value meaning "no key"; seeing any code >= IDLE_CODE re-arms the accept logic
//  STRIDE     4  micro-ROM words per command; base address = rom_num * STRIDE
//  SATURATE   1  1: overflow past 999 clamps to 999; 0: wraps to 000
// PORTS
//  clk       in   1  system clock, rising edge
//  rst_n     in   1  asynchronous active-low reset
//  rom_num   in   3  command code from key decoder (level, held while key is down)
//  hundreds  out  4  BCD hundreds digit
//  tens      out  4  BCD tens digit
//  ones      out  4  BCD ones digit
//  busy      out  1  high while a micro-program is running
//  done      out  1  one-cycle pulse, the cycle after the END op executes
//  overflow  out  1  sticky; set when a carry leaves the hundreds digit
// BEHAVIOUR
//  Reset (async, rst_n=0): digits=0, busy=0, done=0, overflow=0, carry=0, armed=1, state IDLE, pc=0.
//  Single clock, one clock domain. No input synchroniser; rom_num must already be synchronous.
//  States: IDLE, RUN.
//   IDLE: if armed && rom_num<IDLE_CODE -> latch pc=rom_num*STRIDE, armed=0, busy=1, go to RUN.
//         if rom_num>=IDLE_CODE -> armed=1. Otherwise hold.
//   RUN: execute rom[pc], pc=pc+1. On END -> busy=0, go to IDLE, done=1 next cycle.
//  Edge-triggered acceptance: a held key runs exactly once.
//   Re-arm only by observing a code >= IDLE_CODE while IDLE.
//   rom_num changes or codes during RUN are ignored. A direct 1->2 change without an idle code is ignored.
//  Micro-op word = {op[1:0], dsel[1:0]}. dsel: 0 ones, 1 tens, 2 hundreds.
//   INC d   : d==9 -> d=0, carry=1; else d=d+1, carry=0.
//   CARRY d : if carry, same as INC d; else no change.
//   CLR     : all digits=0, carry=0, overflow=0.
//   END     : no datapath change; terminates the program.
//  Carry out of hundreds: overflow=1.
//   SATURATE=1 -> digits forced to 9,9,9. SATURATE=0 -> digits stay 0,0,0 (wrap).
//  ROM contents:
//   add one: 0 INC0, 1 CARRY1, 2 CARRY2, 3 END.  add ten: 4 INC1, 5 CARRY2, 6 END.
//   add hundred: 8 INC2, 9 END.  reset: 12 CLR, 13 END.  Unused words are END.
//  Latency (accept edge = T0):
//   add one: ops T1..T4, busy high T1..T4, done T5.
//   add ten: done T4.  add hundred: done T3.  reset: done T3.
//  Digit updates are visible the cycle after the op executes. Digits never leave 0..9.
//  Reset mid-program: abort immediately, all state cleared as above, no done pulse.
// STRUCTURE
//  Shared package vending_pkg:
//   - command code localparams (CMD_ONE..CMD_RST, CMD_IDLE)
//   - opcode localparams (OP_INC, OP_CARRY, OP_CLR, OP_END)
//   - digit-select constants
//   - helper function bcd_inc(digit) -> {carry, digit}
//  Sub-module credit_micro_rom: combinational 16x4 table, addr[3:0] -> {op, dsel}.
//  Top: FSM, pc, armed flag, carry flag, digit registers, overflow flag.
// TESTING
//  1. Reset; rom_num=4, then 0 held for 10 cycles -> ones=1, one done pulse, busy high exactly 4 cycles.
//  2. Credit 009; press code 0 -> 010. Credit 099; press code 0 -> 100 with done at T5.
//  3. Credit 950; press code 2 -> SATURATE=1: 999, overflow=1. SATURATE=0: 050, overflow=1.
//  4. Credit 123 with overflow=1; press code 3 -> 000, overflow=0, done at T3.
//  5. Code 1 held, then 2 without an intervening 4 -> only +10 applied.
//     Code 0 toggled during RUN -> no second execution.
//  6. Assert rst_n low at T2 of an add-one -> outputs all zero asynchronously, no done.
//     After release, code 4 then 2 -> credit 100.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared definitions for the credit micro-sequencer: command codes, micro-op encoding,
// digit selects, FSM state type and the BCD increment helper.
package vending_pkg;

    localparam logic [2:0] CMD_ONE  = 3'd0;
    localparam logic [2:0] CMD_TEN  = 3'd1;
    localparam logic [2:0] CMD_HUN  = 3'd2;
    localparam logic [2:0] CMD_RST  = 3'd3;
    localparam logic [2:0] CMD_IDLE = 3'd4;

    localparam logic [1:0] OP_INC   = 2'd0;
    localparam logic [1:0] OP_CARRY = 2'd1;
    localparam logic [1:0] OP_CLR   = 2'd2;
    localparam logic [1:0] OP_END   = 2'd3;

    localparam logic [1:0] DSEL_ONES  = 2'd0;
    localparam logic [1:0] DSEL_TENS  = 2'd1;
    localparam logic [1:0] DSEL_HUNDS = 2'd2;

    typedef enum logic {StIdle, StRun} seq_state_e;

    // Returns {carry_out, next_digit}; anything >= 9 rolls over to keep digits in 0..9.
    function automatic logic [4:0] bcd_inc(input logic [3:0] digit);
        if (digit >= 4'd9) begin
            return {1'b1, 4'd0};
        end
        return {1'b0, digit + 4'd1};
    endfunction

endpackage

// File: rtl/credit_micro_rom.sv
// Combinational 16x4 micro-program store; each command owns a 4-word slot at
// {cmd[1:0], offset[1:0]}.
module credit_micro_rom (
    input  logic [3:0] addr_i,
    output logic [1:0] op_o,
    output logic [1:0] dsel_o
);
    import vending_pkg::*;

    logic [3:0] word;

    always_comb begin
        word = {OP_END, DSEL_ONES};
        case (addr_i)
            {CMD_ONE[1:0], 2'd0}: word = {OP_INC,   DSEL_ONES};
            {CMD_ONE[1:0], 2'd1}: word = {OP_CARRY, DSEL_TENS};
            {CMD_ONE[1:0], 2'd2}: word = {OP_CARRY, DSEL_HUNDS};
            {CMD_TEN[1:0], 2'd0}: word = {OP_INC,   DSEL_TENS};
            {CMD_TEN[1:0], 2'd1}: word = {OP_CARRY, DSEL_HUNDS};
            {CMD_HUN[1:0], 2'd0}: word = {OP_INC,   DSEL_HUNDS};
            {CMD_RST[1:0], 2'd0}: word = {OP_CLR,   DSEL_ONES};
            default:              word = {OP_END,   DSEL_ONES};
        endcase
    end

    assign op_o   = word[3:2];
    assign dsel_o = word[1:0];

endmodule

// File: rtl/credit_rom_sequencer.sv
// Runs one micro-program per key press against a 3-digit BCD credit balance,
// one micro-op per clock, with edge-triggered (re-arm on idle code) acceptance.
module credit_rom_sequencer
    import vending_pkg::*;
#(
    parameter int unsigned IDLE_CODE = 32'(CMD_IDLE),
    parameter int unsigned STRIDE    = 4,
    parameter int unsigned SATURATE  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] rom_num,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       busy,
    output logic       done,
    output logic       overflow
);

    seq_state_e state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic       armed_q, armed_d;
    logic       carry_q, carry_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] hund_q, hund_d;
    logic       ovf_q, ovf_d;
    logic       done_q, done_d;

    logic [1:0] rom_op;
    logic [1:0] rom_dsel;
    logic       is_cmd;
    logic [3:0] cur_digit;
    logic [4:0] inc_res;

    credit_micro_rom u_rom (
        .addr_i (pc_q),
        .op_o   (rom_op),
        .dsel_o (rom_dsel)
    );

    assign is_cmd = 32'(rom_num) < IDLE_CODE;

    always_comb begin
        case (rom_dsel)
            DSEL_TENS:  cur_digit = tens_q;
            DSEL_HUNDS: cur_digit = hund_q;
            default:    cur_digit = ones_q;
        endcase
    end

    assign inc_res = bcd_inc(cur_digit);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        armed_d = armed_q;
        carry_d = carry_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        hund_d  = hund_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (armed_q && is_cmd) begin
                    pc_d    = 4'(32'(rom_num) * STRIDE);
                    armed_d = 1'b0;
                    state_d = StRun;
                end else if (!is_cmd) begin
                    armed_d = 1'b1;
                end
            end
            StRun: begin
                pc_d = pc_q + 4'd1;
                if (rom_op == OP_END) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (rom_op == OP_CLR) begin
                    ones_d  = 4'd0;
                    tens_d  = 4'd0;
                    hund_d  = 4'd0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end else if (rom_op == OP_INC || carry_q) begin
                    carry_d = inc_res[4];
                    case (rom_dsel)
                        DSEL_ONES: ones_d = inc_res[3:0];
                        DSEL_TENS: tens_d = inc_res[3:0];
                        DSEL_HUNDS: begin
                            hund_d = inc_res[3:0];
                            // Carry leaving the hundreds digit is a balance overflow.
                            if (inc_res[4]) begin
                                ovf_d = 1'b1;
                                if (SATURATE != 0) begin
                                    ones_d = 4'd9;
                                    tens_d = 4'd9;
                                    hund_d = 4'd9;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= 4'd0;
            armed_q <= 1'b1;
            carry_q <= 1'b0;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            hund_q  <= 4'd0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            armed_q <= armed_d;
            carry_q <= carry_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            hund_q  <= hund_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign hundreds = hund_q;
    assign tens     = tens_q;
    assign ones     = ones_q;
    assign busy     = (state_q == StRun);
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_credit_rom_sequencer.sv
// Bench for credit_rom_sequencer: saturating and wrapping instances share stimulus and
// are compared each cycle against a credit-value model plus directed command tables.
module tb_credit_rom_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rom_num;

    logic [3:0] h_s, t_s, o_s, h_w, t_w, o_w;
    logic       busy_s, done_s, ovf_s, busy_w, done_w, ovf_w;

    credit_rom_sequencer #(.IDLE_CODE(4), .STRIDE(4), .SATURATE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .rom_num(rom_num),
        .hundreds(h_s), .tens(t_s), .ones(o_s),
        .busy(busy_s), .done(done_s), .overflow(ovf_s)
    );

    credit_rom_sequencer #(.IDLE_CODE(4), .STRIDE(4), .SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .rom_num(rom_num),
        .hundreds(h_w), .tens(t_w), .ones(o_w),
        .busy(busy_w), .done(done_w), .overflow(ovf_w)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;

    // Model: credit as an integer 0..999 per instance (index 0 saturating, 1 wrapping).
    int m_cnt;
    bit m_armed;
    bit m_done;
    int m_cmd;
    int m_val[2];
    bit m_ovf[2];

    typedef struct {
        logic [2:0] code;
        int         reps;
        int         exp_s;
        int         ovf_s;
        int         exp_w;
        int         ovf_w;
        int         lat;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    function automatic int prog_len(input int code);
        case (code)
            0:       return 4;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_armed = 1'b1;
        m_done  = 1'b0;
        m_cmd   = 0;
        for (int s = 0; s < 2; s++) begin
            m_val[s] = 0;
            m_ovf[s] = 1'b0;
        end
    endtask

    task automatic model_apply();
        int v;
        for (int s = 0; s < 2; s++) begin
            if (m_cmd == 3) begin
                m_val[s] = 0;
                m_ovf[s] = 1'b0;
            end else begin
                v = m_val[s] + (m_cmd == 0 ? 1 : (m_cmd == 1 ? 10 : 100));
                if (v > 999) begin
                    m_ovf[s] = 1'b1;
                    v = (s == 0) ? 999 : v - 1000;
                end
                m_val[s] = v;
            end
        end
    endtask

    task automatic model_edge();
        m_done = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_done = 1'b1;
                model_apply();
            end
        end else if (m_armed && rom_num < 3'd4) begin
            m_armed = 1'b0;
            m_cmd   = int'(rom_num);
            m_cnt   = prog_len(m_cmd);
        end else if (rom_num >= 3'd4) begin
            m_armed = 1'b1;
        end
    endtask

    task automatic compare();
        chk("busy_sat", int'(busy_s), int'(m_cnt > 0));
        chk("busy_wrap", int'(busy_w), int'(m_cnt > 0));
        chk("done_sat", int'(done_s), int'(m_done));
        chk("done_wrap", int'(done_w), int'(m_done));
        if (m_cnt == 0) begin
            chk("credit_sat", int'({h_s, t_s, o_s}), to_bcd(m_val[0]));
            chk("credit_wrap", int'({h_w, t_w, o_w}), to_bcd(m_val[1]));
            chk("ovf_sat", int'(ovf_s), int'(m_ovf[0]));
            chk("ovf_wrap", int'(ovf_w), int'(m_ovf[1]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        compare();
        if (done_s) done_seen++;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_credit_sat"}, int'({h_s, t_s, o_s}), 0);
        chk({tag, "_credit_wrap"}, int'({h_w, t_w, o_w}), 0);
        chk({tag, "_flags_sat"}, int'({busy_s, done_s, ovf_s}), 0);
        chk({tag, "_flags_wrap"}, int'({busy_w, done_w, ovf_w}), 0);
    endtask

    // Idle code for a cycle, then hold the key until done (bounded), plus two held cycles.
    task automatic press(input logic [2:0] code, output int lat, output int busy_n);
        rom_num = 3'd4;
        step();
        rom_num = code;
        lat     = 0;
        busy_n  = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            step();
            if (busy_s) busy_n++;
            if (done_s) lat = i;
        end
        step();
        step();
        rom_num = 3'd4;
    endtask

    initial begin
        int lat, busy_n, hold;

        vecs[0]  = '{3'd0, 9, 9,   0, 9,   0, 5};
        vecs[1]  = '{3'd0, 1, 10,  0, 10,  0, 5};
        vecs[2]  = '{3'd1, 8, 90,  0, 90,  0, 4};
        vecs[3]  = '{3'd0, 9, 99,  0, 99,  0, 5};
        vecs[4]  = '{3'd0, 1, 100, 0, 100, 0, 5};
        vecs[5]  = '{3'd3, 1, 0,   0, 0,   0, 3};
        vecs[6]  = '{3'd2, 9, 900, 0, 900, 0, 3};
        vecs[7]  = '{3'd1, 5, 950, 0, 950, 0, 4};
        vecs[8]  = '{3'd2, 1, 999, 1, 50,  1, 3};
        vecs[9]  = '{3'd1, 1, 999, 1, 60,  1, 4};
        vecs[10] = '{3'd3, 1, 0,   0, 0,   0, 3};
        vecs[11] = '{3'd2, 9, 900, 0, 900, 0, 3};
        vecs[12] = '{3'd1, 9, 990, 0, 990, 0, 4};
        vecs[13] = '{3'd0, 9, 999, 0, 999, 0, 5};
        vecs[14] = '{3'd0, 1, 999, 1, 0,   1, 5};
        vecs[15] = '{3'd1, 1, 999, 1, 10,  1, 4};
        vecs[16] = '{3'd3, 1, 0,   0, 0,   0, 3};

        rst_n   = 1'b0;
        rom_num = 3'd4;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Single held add-one: one run, busy exactly 4 cycles, one done pulse.
        done_seen = 0;
        rom_num   = 3'd0;
        busy_n    = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy_s) busy_n++;
        end
        chk("held_busy_cycles", busy_n, 4);
        chk("held_done_pulses", done_seen, 1);
        chk("held_ones", int'(o_s), 1);
        rom_num = 3'd4;
        press(3'd3, lat, busy_n);

        for (int v = 0; v < 17; v++) begin
            for (int r = 0; r < vecs[v].reps; r++) begin
                press(vecs[v].code, lat, busy_n);
                chk($sformatf("vec%0d_latency", v), lat, vecs[v].lat);
                chk($sformatf("vec%0d_busy", v), busy_n, vecs[v].lat - 1);
            end
            chk($sformatf("vec%0d_credit_sat", v), int'({h_s, t_s, o_s}), to_bcd(vecs[v].exp_s));
            chk($sformatf("vec%0d_ovf_sat", v), int'(ovf_s), vecs[v].ovf_s);
            chk($sformatf("vec%0d_credit_wrap", v), int'({h_w, t_w, o_w}), to_bcd(vecs[v].exp_w));
            chk($sformatf("vec%0d_ovf_wrap", v), int'(ovf_w), vecs[v].ovf_w);
        end

        // Code 1 held then 2 with no idle code between: only +10.
        done_seen = 0;
        rom_num = 3'd4;
        step();
        rom_num = 3'd1;
        repeat (8) step();
        rom_num = 3'd2;
        repeat (8) step();
        rom_num = 3'd4;
        step();
        chk("no_rearm_credit", int'({h_s, t_s, o_s}), to_bcd(10));
        chk("no_rearm_dones", done_seen, 1);

        // Key toggled while running must not queue a second run.
        done_seen = 0;
        rom_num = 3'd0;
        step();
        rom_num = 3'd4;
        step();
        rom_num = 3'd0;
        step();
        rom_num = 3'd4;
        step();
        rom_num = 3'd0;
        repeat (8) step();
        chk("toggle_credit", int'({h_s, t_s, o_s}), to_bcd(11));
        chk("toggle_dones", done_seen, 1);

        // Asynchronous reset in the middle of an add-one.
        rom_num = 3'd4;
        step();
        rom_num = 3'd0;
        step();
        step();
        chk("pre_reset_busy", int'(busy_s), 1);
        #1 rst_n = 1'b0;
        #1 check_zero("async_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_zero("reset_held");
        rom_num = 3'd4;
        rst_n   = 1'b1;
        step();
        step();
        press(3'd2, lat, busy_n);
        chk("post_reset_latency", lat, 3);
        chk("post_reset_credit", int'({h_s, t_s, o_s}), to_bcd(100));

        // Random key activity against the model.
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 2) == 0) rom_num = 3'($urandom_range(4, 7));
                else rom_num = 3'($urandom_range(0, 3));
                hold = int'($urandom_range(1, 6));
            end
            hold--;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
